// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fc_pkg
// Brief   : Shared types and helpers for the multi-lane FC neuron engine:
//           FSM state encoding, ceil-log2 and the output saturation function.
// Revision: 1.0 - initial release
// ============================================================================
package fc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fc_state_e;

   // Saturation result: clamp flag plus a value wide enough for any OUT_WIDTH <= 64
   typedef struct packed {
      logic        sat;
      logic [63:0] val;
   } fc_sat_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Clamp a 65-bit signed value to the signed or unsigned out_w-bit range
   function automatic fc_sat_t saturate(input logic signed [64:0] x,
                                        input int                 out_w,
                                        input logic               is_signed);
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      fc_sat_t            r;
      if (is_signed) begin
         hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
         lo = -(65'sd1 <<< (out_w - 1));
      end else begin
         hi = (65'sd1 <<< out_w) - 65'sd1;
         lo = 65'sd0;
      end
      r.sat = 1'b0;
      r.val = x[63:0];
      if (x > hi) begin
         r.sat = 1'b1;
         r.val = hi[63:0];
      end else if (x < lo) begin
         r.sat = 1'b1;
         r.val = lo[63:0];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_multi_lane_core_tree.sv
`default_nettype none
// ============================================================================
// Module  : fc_lane_adder_tree
// Brief   : Registered balanced adder tree summing LANES products. Each leaf
//           is sign- or zero-extended to the full sum width before adding.
// Revision: 1.0 - initial release
// ============================================================================
module fc_lane_adder_tree #(
   parameter int PROD_WIDTH = 16,
   parameter int LANES      = 4
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic                                      signed_i,
   input  logic [LANES*PROD_WIDTH-1:0]               prod_i,
   output logic [PROD_WIDTH+fc_pkg::clog2(LANES)-1:0] sum_o
);
   import fc_pkg::*;

   localparam int SUM_WIDTH = PROD_WIDTH + clog2(LANES);

   // Heap-ordered tree: node 0 is the root, leaves occupy LANES-1 .. 2*LANES-2
   logic [SUM_WIDTH-1:0] node_w [0:2*LANES-2];
   logic [SUM_WIDTH-1:0] sum_d;
   logic [SUM_WIDTH-1:0] sum_q;

   for (genvar k = 0; k < LANES; k++) begin : g_leaf
      assign node_w[LANES-1+k] = signed_i
         ? SUM_WIDTH'($signed(prod_i[k*PROD_WIDTH +: PROD_WIDTH]))
         : SUM_WIDTH'(prod_i[k*PROD_WIDTH +: PROD_WIDTH]);
   end

   for (genvar i = 0; i < LANES - 1; i++) begin : g_node
      assign node_w[i] = node_w[2*i+1] + node_w[2*i+2];
   end

   // Root of the tree feeds the stage register
   always_comb begin
      sum_d = node_w[0];
   end

   // Stage register holding the lane sum
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/fc_multi_lane_core.sv
`default_nettype none
// ============================================================================
// Module  : fc_multi_lane_core
// Brief   : Multi-lane fully connected neuron engine. Per beat, LANES products
//           are registered, tree-summed, and accumulated onto a bias; the last
//           beat triggers shift/ReLU/saturate and a valid/ready handoff.
// Revision: 1.0 - initial release
// ============================================================================
module fc_multi_lane_core #(
   parameter int IN_DATA_WIDTH = 8,
   parameter int LANES         = 4,
   parameter int ACC_WIDTH     = 32,
   parameter int OUT_WIDTH     = 16,
   parameter int OUT_SHIFT     = 0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             run_i,
   input  logic [ACC_WIDTH-1:0]             bias_i,
   input  logic                             signed_i,
   input  logic                             relu_i,
   input  logic                             valid_i,
   input  logic                             last_i,
   output logic                             in_ready_o,
   input  logic [LANES*IN_DATA_WIDTH-1:0]   node_i,
   input  logic [LANES*IN_DATA_WIDTH-1:0]   weight_i,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [OUT_WIDTH-1:0]             result_o,
   output logic                             sat_o,
   output logic                             busy_o
);
   import fc_pkg::*;

   localparam int PW = 2 * IN_DATA_WIDTH;
   localparam int SW = PW + clog2(LANES);

   fc_state_e              state_q, state_d;
   logic [LANES*PW-1:0]    prod_q, prod_d;
   logic                   s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
   logic                   s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
   logic                   s3_last_q, s3_last_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   signed_q, signed_d, relu_q, relu_d;
   logic [OUT_WIDTH-1:0]   result_q, result_d;
   logic                   sat_q, sat_d, valid_q, valid_d;
   logic                   in_ready_q, in_ready_d, busy_q, busy_d;

   logic                   accept_w;
   logic                   mult_signed_w;
   logic [SW-1:0]          sum_w;
   logic [ACC_WIDTH-1:0]   sum_ext_w;
   logic signed [64:0]     acc_ext_w;
   logic signed [64:0]     shifted_w;
   fc_sat_t                sres_w;
   logic [OUT_WIDTH-1:0]   pp_result_w;
   logic                   pp_sat_w;
   logic                   unused_sat_hi;

   // A beat issued together with run_i belongs to the new neuron, so it is
   // accepted and multiplied in the mode being loaded on this same edge.
   assign accept_w      = valid_i & (run_i | in_ready_q);
   assign mult_signed_w = run_i ? signed_i : signed_q;

   // S1: per-lane products, signed or unsigned according to the active mode
   always_comb begin
      prod_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (mult_signed_w) begin
            prod_d[k*PW +: PW] = PW'($signed(node_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]))
                               * PW'($signed(weight_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]));
         end else begin
            prod_d[k*PW +: PW] = PW'(node_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH])
                               * PW'(weight_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
         end
      end
   end

   fc_lane_adder_tree #(
      .PROD_WIDTH (PW),
      .LANES      (LANES)
   ) u_tree (
      .clk      (clk),
      .reset_n  (reset_n),
      .signed_i (signed_q),
      .prod_i   (prod_q),
      .sum_o    (sum_w)
   );

   assign sum_ext_w = signed_q ? ACC_WIDTH'($signed(sum_w)) : ACC_WIDTH'(sum_w);

   // Post-processing: shift, ReLU, then clamp to the output range
   always_comb begin
      acc_ext_w   = signed_q ? 65'($signed(acc_q)) : 65'(acc_q);
      shifted_w   = acc_ext_w >>> OUT_SHIFT;
      sres_w      = saturate(shifted_w, OUT_WIDTH, signed_q);
      pp_result_w = sres_w.val[OUT_WIDTH-1:0];
      pp_sat_w    = sres_w.sat;
      if (relu_q && (shifted_w < 65'sd0)) begin
         pp_result_w = '0;
         pp_sat_w    = 1'b0;
      end
   end

   assign unused_sat_hi = ^sres_w.val[63:OUT_WIDTH];

   // Next-state: pipeline valids, accumulator, mode capture, FSM and output reg.
   // run_i flushes in-flight beats and drops any held result.
   always_comb begin
      s1_vld_d  = accept_w;
      s1_last_d = accept_w & last_i;
      s2_vld_d  = s1_vld_q & ~run_i;
      s2_last_d = s1_last_q;
      s3_last_d = s2_vld_q & s2_last_q & ~run_i;

      acc_d = acc_q;
      if (run_i) begin
         acc_d = bias_i;
      end else if (s2_vld_q) begin
         acc_d = acc_q + sum_ext_w;
      end

      signed_d = run_i ? signed_i : signed_q;
      relu_d   = run_i ? relu_i   : relu_q;

      state_d = state_q;
      if (run_i) begin
         state_d = (accept_w && last_i) ? ST_DRAIN : ST_ACCUM;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_ACCUM: if (accept_w && last_i) state_d = ST_DRAIN;
            ST_DRAIN: if (s3_last_q)          state_d = ST_HOLD;
            ST_HOLD:  if (ready_i)            state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      result_d = result_q;
      sat_d    = sat_q;
      valid_d  = valid_q;
      if (run_i) begin
         valid_d = 1'b0;
      end else if (s3_last_q) begin
         result_d = pp_result_w;
         sat_d    = pp_sat_w;
         valid_d  = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      in_ready_d = (state_d == ST_ACCUM);
      busy_d     = (state_d != ST_IDLE);
   end

   // Single register bank: FSM state, its registered outputs and the datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         prod_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_last_q  <= 1'b0;
         s3_last_q  <= 1'b0;
         acc_q      <= '0;
         signed_q   <= 1'b0;
         relu_q     <= 1'b0;
         result_q   <= '0;
         sat_q      <= 1'b0;
         valid_q    <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prod_q     <= prod_d;
         s1_vld_q   <= s1_vld_d;
         s1_last_q  <= s1_last_d;
         s2_vld_q   <= s2_vld_d;
         s2_last_q  <= s2_last_d;
         s3_last_q  <= s3_last_d;
         acc_q      <= acc_d;
         signed_q   <= signed_d;
         relu_q     <= relu_d;
         result_q   <= result_d;
         sat_q      <= sat_d;
         valid_q    <= valid_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready_o = in_ready_q;
   assign valid_o    = valid_q;
   assign result_o   = result_q;
   assign sat_o      = sat_q;
   assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_multi_lane_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_fc_multi_lane_core
// Brief   : Scoreboard bench for fc_multi_lane_core. Two instances share the
//           stimulus: one with OUT_SHIFT=0 and one with OUT_SHIFT=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fc_multi_lane_core;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run_i = 1'b0, signed_i = 1'b0, relu_i = 1'b0;
   logic        valid_i = 1'b0, last_i = 1'b0, ready_i = 1'b0;
   logic [31:0] bias_i = '0, node_i = '0, weight_i = '0;

   logic        in_ready_o, valid_o, sat_o, busy_o;
   logic [15:0] result_o;
   logic        in_ready_s, valid_s, sat_s, busy_s;
   logic [15:0] result_s;

   int          total = 0;
   int          bad   = 0;
   logic [16:0] q0[$];
   logic [16:0] q1[$];
   logic [16:0] e0, e1;

   fc_multi_lane_core dut (
      .clk(clk), .reset_n(reset_n), .run_i(run_i), .bias_i(bias_i),
      .signed_i(signed_i), .relu_i(relu_i), .valid_i(valid_i), .last_i(last_i),
      .in_ready_o(in_ready_o), .node_i(node_i), .weight_i(weight_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
      .sat_o(sat_o), .busy_o(busy_o)
   );

   fc_multi_lane_core #(.OUT_SHIFT(4)) dut_sh (
      .clk(clk), .reset_n(reset_n), .run_i(run_i), .bias_i(bias_i),
      .signed_i(signed_i), .relu_i(relu_i), .valid_i(valid_i), .last_i(last_i),
      .in_ready_o(in_ready_s), .node_i(node_i), .weight_i(weight_i),
      .valid_o(valid_s), .ready_i(ready_i), .result_o(result_s),
      .sat_o(sat_s), .busy_o(busy_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: exact integer arithmetic on the spec's rules
   function automatic longint beat_sum(input logic [31:0] n, input logic [31:0] w, input bit s);
      longint t = 0;
      for (int k = 0; k < 4; k++) begin
         if (s) t += longint'($signed(n[k*8 +: 8])) * longint'($signed(w[k*8 +: 8]));
         else   t += longint'(n[k*8 +: 8]) * longint'(w[k*8 +: 8]);
      end
      return t;
   endfunction

   function automatic logic [16:0] model(input longint acc, input bit s, input bit r, input int sh);
      logic [31:0] a;
      longint      v;
      bit          sat;
      a   = acc[31:0];
      v   = s ? longint'($signed(a)) : longint'(a);
      v   = v >>> sh;
      sat = 1'b0;
      if (r && v < 0) v = 0;
      else if (s) begin
         if (v > 32767)       begin v = 32767;  sat = 1'b1; end
         else if (v < -32768) begin v = -32768; sat = 1'b1; end
      end else if (v > 65535) begin v = 65535; sat = 1'b1; end
      return {sat, v[15:0]};
   endfunction

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   // Monitors: pop and compare on every result handshake
   always @(negedge clk) begin
      if (reset_n && valid_o && ready_i) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL res0_unexpected: got %0h want none", {sat_o, result_o});
         end else begin
            e0 = q0.pop_front();
            check("res0", 32'({sat_o, result_o}), 32'(e0));
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && valid_s && ready_i) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL res4_unexpected: got %0h want none", {sat_s, result_s});
         end else begin
            e1 = q1.pop_front();
            check("res4", 32'({sat_s, result_s}), 32'(e1));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] b, input bit s, input bit r);
      run_i = 1'b1; bias_i = b; signed_i = s; relu_i = r;
      tick();
      run_i = 1'b0;
   endtask

   task automatic beat(input logic [31:0] n, input logic [31:0] w, input bit last);
      node_i = n; weight_i = w; valid_i = 1'b1; last_i = last;
      tick();
      valid_i = 1'b0; last_i = 1'b0;
   endtask

   task automatic start_beat(input logic [31:0] b, input bit s, input bit r,
                             input logic [31:0] n, input logic [31:0] w, input bit last);
      run_i = 1'b1; bias_i = b; signed_i = s; relu_i = r;
      beat(n, w, last);
      run_i = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!valid_o && k < 40) begin
         tick();
         k++;
      end
      if (!valid_o) begin
         total++; bad++;
         $display("FAIL wait_valid: got valid_o=0 want 1");
      end
   endtask

   task automatic ready_pulse();
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
   endtask

   task automatic rand_neuron();
      bit          s, r, first;
      int          nb, gap, k;
      logic [31:0] b, n, w;
      longint      acc;
      s     = 1'($urandom % 2);
      r     = 1'($urandom % 2);
      first = 1'($urandom % 2);
      b     = ($urandom % 4 == 0) ? $urandom : (32'($urandom_range(0, 4000)) - 32'd2000);
      nb    = $urandom_range(1, 5);
      acc   = longint'(b);
      for (int i = 0; i < nb; i++) begin
         n = $urandom;
         w = $urandom;
         acc += beat_sum(n, w, s);
         if (i == 0 && first) begin
            start_beat(b, s, r, n, w, nb == 1);
         end else begin
            if (i == 0) start(b, s, r);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) tick();
            beat(n, w, i == nb - 1);
         end
      end
      q0.push_back(model(acc, s, r, 0));
      q1.push_back(model(acc, s, r, 4));
      k = 0;
      while (busy_o && k < 60) begin
         ready_i = ($urandom % 3 == 0);
         tick();
         k++;
      end
      ready_i = 1'b0;
      if (busy_o) begin
         total++; bad++;
         $display("FAIL rand_drain: got busy_o=1 want 0");
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_valid", 32'(valid_o), 0);
      check("rst_in_ready", 32'(in_ready_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_result", 32'(result_o), 0);
      check("rst_sat", 32'(sat_o), 0);

      // Unsigned two-beat neuron and output latency
      start(32'd0, 1'b0, 1'b0);
      check("accum_in_ready", 32'(in_ready_o), 1);
      check("accum_busy", 32'(busy_o), 1);
      q0.push_back({1'b0, 16'd140});
      q1.push_back({1'b0, 16'd8});
      beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
      beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
      check("drain_in_ready", 32'(in_ready_o), 0);
      wait_valid(k);
      check("latency", 32'(k), 3);
      ready_pulse();
      check("post_hs_valid", 32'(valid_o), 0);
      check("post_hs_busy", 32'(busy_o), 0);

      // Signed with negative lane, then ReLU
      start(32'd10, 1'b1, 1'b0);
      q0.push_back({1'b0, 16'd4});
      q1.push_back({1'b0, 16'd0});
      beat(pk(253, 0, 0, 0), pk(2, 0, 0, 0), 1'b1);
      wait_valid(k);
      ready_pulse();
      start(32'd0, 1'b1, 1'b1);
      q0.push_back({1'b0, 16'd0});
      q1.push_back({1'b0, 16'd0});
      beat(pk(253, 0, 0, 0), pk(2, 0, 0, 0), 1'b1);
      wait_valid(k);
      ready_pulse();

      // Unsigned saturation; signed shifted negative
      start(32'd0, 1'b0, 1'b0);
      q0.push_back({1'b1, 16'hFFFF});
      q1.push_back({1'b0, 16'd16256});
      beat(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 1'b1);
      wait_valid(k);
      ready_pulse();
      start(32'hFFFF_FC18, 1'b1, 1'b0);
      q0.push_back({1'b0, 16'hFC18});
      q1.push_back({1'b0, 16'hFFC1});
      beat(32'd0, 32'd0, 1'b1);
      wait_valid(k);
      ready_pulse();

      // Backpressure in HOLD (run_i together with the only beat)
      q0.push_back({1'b0, 16'd9});
      q1.push_back({1'b0, 16'd0});
      start_beat(32'd5, 1'b0, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1);
      wait_valid(k);
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", 32'(valid_o), 1);
         check("hold_result", 32'(result_o), 9);
         check("hold_in_ready", 32'(in_ready_o), 0);
         tick();
      end
      ready_pulse();
      check("hold_exit_busy", 32'(busy_o), 0);

      // Abort during ACCUM with beats in flight
      start(32'd100, 1'b0, 1'b0);
      beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9), 1'b0);
      beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9), 1'b0);
      start(32'd50, 1'b0, 1'b0);
      q0.push_back({1'b0, 16'd51});
      q1.push_back({1'b0, 16'd3});
      beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1);
      wait_valid(k);
      ready_pulse();
      // Abort during HOLD: held result dropped
      start(32'd200, 1'b0, 1'b0);
      beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1);
      wait_valid(k);
      tick();
      tick();
      q0.push_back({1'b0, 16'd7});
      q1.push_back({1'b0, 16'd0});
      start_beat(32'd1, 1'b0, 1'b0, pk(2, 0, 0, 0), pk(3, 0, 0, 0), 1'b1);
      check("abort_valid_drop", 32'(valid_o), 0);
      wait_valid(k);
      ready_pulse();

      // Asynchronous reset while in DRAIN
      start(32'd3, 1'b0, 1'b0);
      beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(valid_o), 0);
      check("arst_result", 32'(result_o), 0);
      check("arst_busy", 32'(busy_o), 0);
      check("arst_in_ready", 32'(in_ready_o), 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("arst_no_valid", 32'(valid_o), 0);
      end

      // Randomized neurons
      repeat (40) rand_neuron();

      check("queues_empty", 32'(q0.size() + q1.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
